lut_rev_finder: RTL

//  Reverse of the dm pointer lookup table: given an 8-bit data-memory address,

---
 rtl/lut_rev_finder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lut_rev_finder.sv
// Reverse dm-pointer lookup: scans a writable copy of the pointer table, one entry per cycle.
// Optional full-table scan with multi-match flag: define LUT_REV_MULTI_HIT_EN.
module lut_rev_finder #(
   parameter int PW = 5,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start_i,
   input  logic [DW-1:0] addr_i,
   input  logic          wr_en_i,
   input  logic [PW-1:0] wr_idx_i,
   input  logic [DW-1:0] wr_dat_i,
   output logic          busy_o,
   output logic          done_o,
   output logic          hit_o,
   output logic [PW-1:0] ptr_o,
`ifdef LUT_REV_MULTI_HIT_EN
   output logic          multi_o,
`endif
   output logic          wr_err_o
);

   localparam int            DEPTH    = 1 << PW;
   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state_q, state_d;

   logic [DW-1:0] tbl_q [DEPTH];
   logic [DW-1:0] key_q;
   logic [PW-1:0] idx_q;
   logic          match, last;

   // Power-on contents mirror the forward pointer LUT.
   function automatic logic [DW-1:0] dflt(input int i);
      case (i)
         0:       dflt = DW'(14);
         1:       dflt = DW'(20);
         2:       dflt = DW'(127);
         4:       dflt = DW'(15);
         5:       dflt = DW'(5);
         6:       dflt = DW'(6);
         7:       dflt = DW'(32);
         8:       dflt = DW'(64);
         9:       dflt = DW'(7);
         default: dflt = '0;
      endcase
   endfunction

   assign match  = (tbl_q[idx_q] == key_q);
   assign last   = (idx_q == LAST_IDX);
   assign busy_o = (state_q == SCAN);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_i) state_d = SCAN;
`ifdef LUT_REV_MULTI_HIT_EN
         SCAN: if (last) state_d = DONE;
`else
         SCAN: if (match || last) state_d = DONE;
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Writes are blocked only while scanning; a write in the start cycle lands before entry 0 is compared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) tbl_q[i] <= dflt(i);
      end else if (wr_en_i && state_q != SCAN) begin
         tbl_q[wr_idx_i] <= wr_dat_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q    <= '0;
         idx_q    <= '0;
         hit_o    <= 1'b0;
         ptr_o    <= '0;
         done_o   <= 1'b0;
         wr_err_o <= 1'b0;
`ifdef LUT_REV_MULTI_HIT_EN
         multi_o  <= 1'b0;
`endif
      end else begin
         done_o   <= (state_q == DONE);
         wr_err_o <= wr_en_i && (state_q == SCAN);
         case (state_q)
            IDLE: if (start_i) begin
               key_q   <= addr_i;
               idx_q   <= '0;
               hit_o   <= 1'b0;
               ptr_o   <= '0;
`ifdef LUT_REV_MULTI_HIT_EN
               multi_o <= 1'b0;
`endif
            end
            SCAN: begin
`ifdef LUT_REV_MULTI_HIT_EN
               // First match fixes ptr; any later match only flags multi.
               if (match) begin
                  if (!hit_o) begin
                     hit_o <= 1'b1;
                     ptr_o <= idx_q;
                  end else begin
                     multi_o <= 1'b1;
                  end
               end
               if (!last) idx_q <= idx_q + PW'(1);
`else
               if (match) begin
                  hit_o <= 1'b1;
                  ptr_o <= idx_q;
               end else if (last) begin
                  hit_o <= 1'b0;
                  ptr_o <= '0;
               end else begin
                  idx_q <= idx_q + PW'(1);
               end
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
